rgb_hsl_frame_ctrl: RTL and testbench

Frame-level sequencer for the RGB-to-HSL conversion datapath. On a start pulse it scans the RGB pixel memory from address 0 to NUM_PIXELS-1 and clock-enables the memory and the fixed-latency converter pipeline. It tracks in-flight pixels with a valid-token shift register and presents converted HSL pixels on a valid/ready output, stalling the whole pipeline under backpressure. It reports completion with a one-cycle done pulse. It sits between the pixel ROM/converter pair and the downstream sink (frame writer or testbench dump).

---
 rtl/rgb_hsl_frame_ctrl_pkg.sv | 19 +
 rtl/rgb_hsl_frame_ctrl_if.sv | 26 ++
 rtl/rgb_hsl_frame_ctrl_token_pipe.sv | 35 +++
 rtl/rgb_hsl_frame_ctrl.sv | 116 +++++++++++
 tb/tb_rgb_hsl_frame_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_hsl_frame_ctrl_pkg.sv
// Shared types and constants for the RGB-to-HSL frame sequencer.
package rgb_hsl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned H_W = 9;
    localparam int unsigned S_W = 8;
    localparam int unsigned L_W = 8;

    localparam int unsigned DEF_NUM_PIXELS = 100000;
    localparam int unsigned DEF_MEM_LAT    = 1;
    localparam int unsigned DEF_CONV_LAT   = 3;

endpackage

// File: rtl/rgb_hsl_frame_ctrl_if.sv
// Valid/ready HSL pixel stream from the frame sequencer to the sink.
interface rgb_hsl_frame_ctrl_if
    import rgb_hsl_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) ();

    logic              out_valid;
    logic              out_ready;
    logic [H_W-1:0]    out_h;
    logic [S_W-1:0]    out_s;
    logic [L_W-1:0]    out_l;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output out_valid, out_h, out_s, out_l, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_h, out_s, out_l, out_idx, out_last,
        output out_ready
    );

endinterface

// File: rtl/rgb_hsl_frame_ctrl_token_pipe.sv
// D-deep enable-gated shift register tracking in-flight pixels and the last flag.
module hsl_token_pipe #(
    parameter int unsigned D = 4
) (
    input  logic Clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic inj_vld,
    input  logic inj_lst,
    output logic out_vld,
    output logic out_lst
);

    logic [D-1:0] vld;
    logic [D-1:0] lst;

    // Shift-left form keeps D == 1 legal (no [D-2:0] slice).
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            lst <= '0;
        end else if (clr) begin
            vld <= '0;
            lst <= '0;
        end else if (en) begin
            vld <= (vld << 1) | D'(inj_vld);
            lst <= (lst << 1) | D'(inj_lst);
        end
    end

    assign out_vld = vld[D-1];
    assign out_lst = lst[D-1] & vld[D-1];

endmodule

// File: rtl/rgb_hsl_frame_ctrl.sv
// Frame sequencer: scans pixel memory, clock-enables the converter, and
// presents HSL pixels on a valid/ready stream with whole-pipeline stall.
module rgb_hsl_frame_ctrl
    import rgb_hsl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned CONV_LAT   = DEF_CONV_LAT
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_en,
    output logic                  conv_en,
    input  logic [H_W-1:0]        conv_h,
    input  logic [S_W-1:0]        conv_s,
    input  logic [L_W-1:0]        conv_l,
    rgb_hsl_frame_ctrl_if.master  hsl_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned D = MEM_LAT + CONV_LAT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q;
    logic              active, adv, pipe_en, inj, inj_last, flush, accept;
    logic              tok_vld, tok_lst;

    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign adv      = ~tok_vld | hsl_out.out_ready;
    assign pipe_en  = adv & active;
    assign inj      = (state_q == ST_RUN);
    assign inj_last = inj & (addr_q == LAST_ADDR);
    assign flush    = abort & (state_q != ST_IDLE);
    assign accept   = tok_vld & hsl_out.out_ready;

    hsl_token_pipe #(.D(D)) u_tok (
        .Clk     (Clk),
        .rst     (rst),
        .en      (pipe_en),
        .clr     (flush),
        .inj_vld (inj),
        .inj_lst (inj_last),
        .out_vld (tok_vld),
        .out_lst (tok_lst)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                if (adv) begin
                    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (accept && tok_lst) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort outranks every transition, including the final handshake.
        if (flush) begin
            state_d = ST_IDLE;
            addr_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else if (state_q == ST_IDLE && start && !abort) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    assign mem_addr = addr_q;
    assign mem_en   = pipe_en;
    assign conv_en  = pipe_en;
    assign busy     = active;
    assign done     = (state_q == ST_DONE);

    assign hsl_out.out_valid = tok_vld;
    assign hsl_out.out_last  = tok_lst;
    assign hsl_out.out_idx   = idx_q;
    assign hsl_out.out_h     = conv_h;
    assign hsl_out.out_s     = conv_s;
    assign hsl_out.out_l     = conv_l;

endmodule

// File: tb/tb_rgb_hsl_frame_ctrl.sv
// Scoreboard bench for rgb_hsl_frame_ctrl with a behavioural ROM/converter.
module tb_rgb_hsl_frame_ctrl;
    import rgb_hsl_pkg::*;

    localparam int unsigned AW  = 4;
    localparam int unsigned NP  = 8;
    localparam int unsigned ML  = 1;
    localparam int unsigned CL  = 3;
    localparam int unsigned D   = ML + CL;
    localparam int unsigned AW2 = 17;
    localparam int unsigned NP2 = 1000;

    typedef struct packed {
        logic [31:0] idx;
        logic [8:0]  h;
        logic [7:0]  s;
        logic [7:0]  l;
        logic        last;
    } exp_t;

    logic Clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, start2 = 1'b0;
    logic [AW-1:0]  mem_addr;
    logic [AW2-1:0] mem_addr2;
    logic mem_en, conv_en, busy, done;
    logic mem_en2, conv_en2, busy2, done2;
    logic [8:0] conv_h, conv_h2;
    logic [7:0] conv_s, conv_l, conv_s2, conv_l2;

    rgb_hsl_frame_ctrl_if #(.ADDR_W(AW))  hif ();
    rgb_hsl_frame_ctrl_if #(.ADDR_W(AW2)) hif2 ();

    rgb_hsl_frame_ctrl #(.ADDR_W(AW), .NUM_PIXELS(NP), .MEM_LAT(ML), .CONV_LAT(CL)) dut (
        .Clk(Clk), .rst(rst), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_en(mem_en), .conv_en(conv_en),
        .conv_h(conv_h), .conv_s(conv_s), .conv_l(conv_l),
        .hsl_out(hif), .busy(busy), .done(done)
    );

    rgb_hsl_frame_ctrl #(.ADDR_W(AW2), .NUM_PIXELS(NP2)) dut2 (
        .Clk(Clk), .rst(rst), .start(start2), .abort(1'b0),
        .mem_addr(mem_addr2), .mem_en(mem_en2), .conv_en(conv_en2),
        .conv_h(conv_h2), .conv_s(conv_s2), .conv_l(conv_l2),
        .hsl_out(hif2), .busy(busy2), .done(done2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [24:0] pix(int unsigned a);
        logic [8:0] h;
        logic [7:0] s, l;
        h = 9'((a * 37) % 360);
        s = 8'(a * 5 + 1);
        l = 8'(a * 3 + 7);
        return {h, s, l};
    endfunction

    // ROM (1 cycle) + 3-stage converter, all gated by the DUT enables
    logic [24:0] mq = '0, mq2 = '0;
    logic [24:0] cs  [CL] = '{default: '0};
    logic [24:0] cs2 [CL] = '{default: '0};
    always @(posedge Clk) begin
        if (mem_en) mq <= pix(32'(mem_addr));
        if (conv_en) begin
            cs[0] <= mq;
            for (int i = 1; i < CL; i++) cs[i] <= cs[i-1];
        end
        if (mem_en2) mq2 <= pix(32'(mem_addr2));
        if (conv_en2) begin
            cs2[0] <= mq2;
            for (int i = 1; i < CL; i++) cs2[i] <= cs2[i-1];
        end
    end
    assign {conv_h, conv_s, conv_l}    = cs[CL-1];
    assign {conv_h2, conv_s2, conv_l2} = cs2[CL-1];

    int unsigned checks = 0, failures = 0;
    int unsigned cyc = 0;
    int unsigned n_out = 0, n_done = 0, last_hs = 0;
    int unsigned n2 = 0, last2 = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic        hold_chk = 1'b0;
    logic [24:0] held_d;
    logic [AW-1:0] held_a;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (!rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("stall_data_hold", 64'({hif.out_h, hif.out_s, hif.out_l}), 64'(held_d));
                chk("stall_addr_hold", 64'(mem_addr), 64'(held_a));
            end
            hold_chk = hif.out_valid && !hif.out_ready;
            if (hold_chk) begin
                held_d = {hif.out_h, hif.out_s, hif.out_l};
                held_a = mem_addr;
                chk("stall_mem_en", 64'(mem_en), 64'(0));
            end
            if (hif.out_valid && hif.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got idx %0d, required no output", hif.out_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_idx", 64'(hif.out_idx), 64'(mon_e.idx));
                    chk("out_hsl", 64'({hif.out_h, hif.out_s, hif.out_l}), 64'({mon_e.h, mon_e.s, mon_e.l}));
                    chk("out_last", 64'(hif.out_last), 64'(mon_e.last));
                    if (hif.out_last) last_hs = cyc;
                end
            end
            if (done) begin
                n_done++;
                chk("done_after_last", 64'(cyc), 64'(last_hs + 1));
            end
            if (hif2.out_valid) begin
                chk("big_idx", 64'(hif2.out_idx), 64'(n2));
                chk("big_hsl", 64'({hif2.out_h, hif2.out_s, hif2.out_l}), 64'(pix(n2)));
                if (hif2.out_last) last2 = 32'(hif2.out_idx);
                n2++;
            end
        end
    end

    int unsigned t0, n0, d0;
    bit ok;

    task automatic push_frame();
        exp_t e;
        for (int unsigned i = 0; i < NP; i++) begin
            e.idx  = i;
            {e.h, e.s, e.l} = pix(i);
            e.last = (i == NP - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame();
        push_frame();
        n0 = n_out;
        d0 = n_done;
        start = 1'b1;
        @(posedge Clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(int unsigned budget, bit toggle);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        ok = 1'b0;
        for (int unsigned k = 0; k < budget; k++) begin
            if (toggle) hif.out_ready = pat[k % 4];
            @(negedge Clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
        hif.out_ready = 1'b1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
        end
    endtask

    task automatic frame_end_checks();
        chk("frame_outputs", 64'(n_out - n0), 64'(NP));
        chk("frame_done_count", 64'(n_done - d0), 64'(1));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        @(negedge Clk); #1;
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after_frame", 64'(busy), 64'(0));
    endtask

    task automatic wait_addr(int unsigned a);
        ok = 1'b0;
        for (int unsigned k = 0; k < 50; k++) begin
            @(negedge Clk); #1;
            if (busy && mem_addr == AW'(a)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL addr_timeout: got no mem_addr %0d, required it in RUN", a);
        end
    endtask

    initial begin
        hif.out_ready  = 1'b1;
        hif2.out_ready = 1'b1;
        repeat (2) @(posedge Clk); #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_valid", 64'(hif.out_valid), 64'(0));
        chk("rst_last", 64'(hif.out_last), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_idx", 64'(hif.out_idx), 64'(0));
        rst = 1'b1;
        @(posedge Clk); #1;

        // full-rate frame
        start_frame();
        ok = 1'b0;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge Clk); #1;
            if (hif.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("first_valid_latency", 64'(cyc - t0), 64'(D));
        wait_done(100, 1'b0);
        chk("done_cycle", 64'(cyc - t0), 64'(NP + D));
        frame_end_checks();

        // backpressure 1,0,0,1
        @(posedge Clk); #1;
        start_frame();
        wait_done(200, 1'b1);
        frame_end_checks();

        // start ignored mid-frame
        @(posedge Clk); #1;
        start_frame();
        wait_addr(3);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done(100, 1'b0);
        chk("restart_done_cycle", 64'(cyc - t0), 64'(NP + D));
        frame_end_checks();

        // abort in RUN
        @(posedge Clk); #1;
        start_frame();
        wait_addr(5);
        abort = 1'b1;
        @(posedge Clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_valid", 64'(hif.out_valid), 64'(0));
        chk("abort_addr", 64'(mem_addr), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        exp_q.delete();
        repeat (8) @(posedge Clk); #1;
        chk("abort_no_done", 64'(n_done - d0), 64'(0));
        start_frame();
        wait_done(100, 1'b0);
        frame_end_checks();

        // async reset during DRAIN
        @(posedge Clk); #1;
        start_frame();
        wait_addr(NP - 1);
        @(negedge Clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_valid", 64'(hif.out_valid), 64'(0));
        chk("arst_last", 64'(hif.out_last), 64'(0));
        chk("arst_addr", 64'(mem_addr), 64'(0));
        chk("arst_idx", 64'(hif.out_idx), 64'(0));
        chk("arst_mem_en", 64'(mem_en), 64'(0));
        #10;
        rst = 1'b1;
        exp_q.delete();
        repeat (8) @(posedge Clk); #1;
        chk("arst_no_done", 64'(n_done - d0), 64'(0));
        chk("arst_busy_after", 64'(busy), 64'(0));

        // long frame with default latencies
        start2 = 1'b1;
        @(posedge Clk); #1;
        t0 = cyc;
        start2 = 1'b0;
        ok = 1'b0;
        for (int unsigned k = 0; k < 2 * NP2; k++) begin
            @(negedge Clk); #1;
            if (done2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("big_done_seen", 64'(ok), 64'(1));
        chk("big_done_cycle", 64'(cyc - t0 + 1), 64'(NP2 + DEF_MEM_LAT + DEF_CONV_LAT + 1));
        chk("big_count", 64'(n2), 64'(NP2));
        chk("big_last_idx", 64'(last2), 64'(NP2 - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
